// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
//   state_e      : responder FSM states (preload stream, normal bus service)
//   BE_*         : legal store lane masks, relative to lane 0
//   store_t      : lane-shifted store mask and data
//   misaligned() : 1 when a store mask cannot be placed at the given byte lane
package dmem_pkg;

  typedef enum logic [0:0] {StLoad, StRun} state_e;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
  } store_t;

  // An empty mask is a legal no-op; any mask other than B/H/W is illegal.
  function automatic logic misaligned(input logic [3:0] be, input logic [1:0] lane);
    logic bad;
    case (be)
      4'b0000: bad = 1'b0;
      BE_B:    bad = 1'b0;
      BE_H:    bad = lane[0];
      BE_W:    bad = (lane != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment between the CPU bus (lane-0 justified) and memory words.
// Purely combinational.
//   lane     in  byte offset within the addressed word
//   byte_en  in  store mask relative to lane 0
//   wdata    in  store data relative to lane 0
//   rword    in  addressed memory word
//   wmask    out store mask moved to its lanes (overflow lanes dropped)
//   wdata_sh out store data moved to its lanes
//   rdata_sh out memory word shifted down so the addressed byte is in lane 0
//   misalign out store mask illegal at this lane
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [3:0]  byte_en,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_sh,
  output logic        misalign
);

  function automatic store_t store_shift(input logic [3:0] be, input logic [31:0] data,
                                         input logic [1:0] ln);
    store_t s;
    s.mask = be << ln;
    s.data = data << {ln, 3'b000};
    return s;
  endfunction

  // High bytes are zero-filled; sign/zero extension is the CPU's job.
  function automatic logic [31:0] read_shift(input logic [31:0] word, input logic [1:0] ln);
    return word >> {ln, 3'b000};
  endfunction

  function automatic logic misalign_check(input logic [3:0] be, input logic [1:0] ln);
    return misaligned(be, ln);
  endfunction

  store_t st;

  always_comb begin
    st       = store_shift(byte_en, wdata, lane);
    wmask    = st.mask;
    wdata_sh = st.data;
    rdata_sh = read_shift(rword, lane);
    misalign = misalign_check(byte_en, lane);
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder on the CPU dmem bus. After reset it optionally accepts a
// preload stream (bus held idle), then services combinational reads and
// byte/half/word stores, flagging misaligned or out-of-range stores.
//   clk, rst_n          clock, asynchronous active-low reset
//   dmem_addr           byte address from the CPU
//   dmem_data           bidirectional: CPU store data / responder read data
//   dmem_wen            store strobe
//   byte_en             store lane mask relative to lane 0
//   ld_valid/data/last  preload stream in
//   ld_ready            preload word accepted when ld_valid
//   busy                high while preloading
//   err, err_addr       sticky store-error flag and address of the first error
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter bit          PRELOAD = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_addr,
  inout  wire  [31:0] dmem_data,
  input  logic        dmem_wen,
  input  logic [3:0]  byte_en,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        busy,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SPAN     = 33'(4 * DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  // Not reset: contents survive rst_n.
  logic [31:0] mem [DEPTH];

  state_e        state_q, state_d;
  logic [AW-1:0] ld_ptr_q, ld_ptr_d;
  logic          err_q, err_d;
  logic [31:0]   err_addr_q, err_addr_d;

  logic [31:0] off;
  logic [AW-1:0] idx;
  logic [1:0]  lane;
  logic        in_range;
  logic [3:0]  wmask;
  logic [31:0] wdata_sh, rdata_sh, rd_data;
  logic        misalign;
  logic        ld_xfer, store_req, store_bad, store_ok, drive_en;

  // Wrap-around subtraction makes addresses below BASE land far out of range.
  assign off      = dmem_addr - BASE;
  assign idx      = off[AW+1:2];
  assign lane     = off[1:0];
  assign in_range = {1'b0, off} < SPAN;

  dmem_lane_align u_align (
    .lane     (lane),
    .byte_en  (byte_en),
    .wdata    (dmem_data),
    .rword    (mem[idx]),
    .wmask    (wmask),
    .wdata_sh (wdata_sh),
    .rdata_sh (rdata_sh),
    .misalign (misalign)
  );

  assign ld_xfer   = ld_ready && ld_valid;
  assign store_req = rst_n && (state_q == StRun) && dmem_wen;
  assign store_bad = store_req && (misalign || !in_range);
  assign store_ok  = store_req && !store_bad;

  // Bus turnaround: release whenever the CPU may be driving.
  assign drive_en  = (state_q == StRun) && !dmem_wen && rst_n;
  assign rd_data   = in_range ? rdata_sh : 32'h0;
  assign dmem_data = drive_en ? rd_data : 32'hzzzz_zzzz;

  assign err      = err_q;
  assign err_addr = err_addr_q;

  always_comb begin
    state_d    = state_q;
    ld_ptr_d   = ld_ptr_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    ld_ready   = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      StLoad: begin
        ld_ready = rst_n;
        busy     = rst_n;
        if (ld_valid) begin
          // The pointer saturates: the last array word ends the stream.
          if (ld_last || (ld_ptr_q == LAST_PTR)) begin
            state_d = StRun;
          end else begin
            ld_ptr_d = ld_ptr_q + 1'b1;
          end
        end
      end
      StRun: begin
        if (store_bad) begin
          err_d = 1'b1;
          if (!err_q) err_addr_d = dmem_addr;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PRELOAD ? StLoad : StRun;
      ld_ptr_q   <= '0;
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      ld_ptr_q   <= ld_ptr_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_xfer) begin
      mem[ld_ptr_q] <= ld_data;
    end else if (store_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (wmask[k]) mem[idx][8*k +: 8] <= wdata_sh[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: preload stream, table of bus
// reads/stores, bus turnaround, reset mid-load and preload pointer saturation.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] dmem_addr;
  logic        dmem_wen;
  logic [3:0]  byte_en;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        busy;
  logic        err;
  logic [31:0] err_addr;
  wire  [31:0] dmem_data;
  logic        tb_drv;
  logic [31:0] tb_wdata;

  assign dmem_data = tb_drv ? tb_wdata : 32'hzzzz_zzzz;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH   (DEPTH),
    .BASE    (BASE),
    .PRELOAD (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dmem_addr (dmem_addr),
    .dmem_data (dmem_data),
    .dmem_wen  (dmem_wen),
    .byte_en   (byte_en),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .busy      (busy),
    .err       (err),
    .err_addr  (err_addr)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    bit          wr;
    logic [31:0] off;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] exp;
    logic        exp_err;
    logic [31:0] exp_eaddr;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drain_data();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.name, dmem_data, e.exp);
    end
  endtask

  task automatic idle();
    dmem_wen = 1'b0;
    byte_en  = 4'b0000;
    tb_drv   = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string nm);
    @(negedge clk);
    dmem_wen  = 1'b0;
    tb_drv    = 1'b0;
    dmem_addr = addr;
    sb_q.push_back('{nm, exp});
    #2;
    drain_data();
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] data);
    @(negedge clk);
    dmem_addr = addr;
    byte_en   = be;
    tb_wdata  = data;
    tb_drv    = 1'b1;
    dmem_wen  = 1'b1;
    @(posedge clk);
    #1;
    dmem_wen  = 1'b0;
    tb_drv    = 1'b0;
    byte_en   = 4'b0000;
  endtask

  task automatic ld_push(input logic [31:0] data, input logic last, input string nm);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = data;
    ld_last  = last;
    #2;
    check(nm, {31'b0, ld_ready}, 32'd1);
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    #2;
    check({nm, "_busy"}, {31'b0, busy}, 32'd0);
    check({nm, "_ready"}, {31'b0, ld_ready}, 32'd0);
    check({nm, "_err"}, {31'b0, err}, 32'd0);
    check({nm, "_eaddr"}, err_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t rd(input logic [31:0] off, input logic [31:0] exp);
    return '{1'b0, off, 4'b0000, 32'h0, exp, 1'b0, 32'h0};
  endfunction

  function automatic vec_t wr(input logic [31:0] off, input logic [3:0] be,
                              input logic [31:0] data, input logic e,
                              input logic [31:0] eaddr);
    return '{1'b1, off, be, data, 32'h0, e, eaddr};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    dmem_addr = BASE;
    ld_data   = 32'h0;
    tb_wdata  = 32'h0;

    // Reset state: outputs quiet, responder not driving the bus.
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ready", {31'b0, ld_ready}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_eaddr", err_addr, 32'h0);
    tb_drv = 1'b1;
    sb_q.push_back('{"rst_bus_released", 32'h0});
    drain_data();
    tb_drv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("load_busy", {31'b0, busy}, 32'd1);
    check("load_ready", {31'b0, ld_ready}, 32'd1);

    // LOAD: bus ignored. Responder must not drive against a zero from the bench.
    @(negedge clk);
    dmem_addr = BASE;
    tb_drv    = 1'b1;
    tb_wdata  = 32'h0;
    sb_q.push_back('{"load_bus_released", 32'h0});
    #2;
    drain_data();
    tb_drv = 1'b0;
    bus_write(BASE + 32'd64, 4'b1111, 32'h0);
    check("load_no_errcheck", {31'b0, err}, 32'd0);

    ld_push(32'h1111_1111, 1'b0, "ld0_ready");
    ld_push(32'h2222_2222, 1'b0, "ld1_ready");
    ld_push(32'h3333_3333, 1'b0, "ld2_ready");
    ld_push(32'h4444_4444, 1'b1, "ld3_ready");
    check("busy_after_last", {31'b0, busy}, 32'd0);
    check("ready_after_last", {31'b0, ld_ready}, 32'd0);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = 32'h5555_5555;
    #2;
    check("ld_extra_ready", {31'b0, ld_ready}, 32'd0);
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    bus_read(BASE + 32'd8, 32'h3333_3333, "read_word2");

    // Store/read table, RUN state.
    vecs.push_back(rd(32'd0,  32'h1111_1111));
    vecs.push_back(rd(32'd5,  32'h0022_2222));
    vecs.push_back(wr(32'd5,  4'b0001, 32'h0000_00AB, 1'b0, 32'h0));
    vecs.push_back(rd(32'd4,  32'h2222_AB22));
    vecs.push_back(rd(32'd5,  32'h0022_22AB));
    vecs.push_back(wr(32'd2,  4'b0011, 32'h0000_BEEF, 1'b0, 32'h0));
    vecs.push_back(rd(32'd0,  32'hBEEF_1111));
    vecs.push_back(rd(32'd2,  32'h0000_BEEF));
    vecs.push_back(rd(32'd3,  32'h0000_00BE));
    vecs.push_back(wr(32'd6,  4'b1111, 32'hCAFE_F00D, 1'b1, BASE + 32'd6));
    vecs.push_back(rd(32'd4,  32'h2222_AB22));
    vecs.push_back(rd(32'd64, 32'h0));
    vecs.push_back(wr(32'd64, 4'b1111, 32'h1234_5678, 1'b1, BASE + 32'd6));
    vecs.push_back(rd(32'hFFFF_FFFC, 32'h0));
    vecs.push_back(wr(32'd1,  4'b0011, 32'h0000_1234, 1'b1, BASE + 32'd6));
    vecs.push_back(rd(32'd0,  32'hBEEF_1111));
    vecs.push_back(wr(32'd12, 4'b0000, 32'hFFFF_FFFF, 1'b1, BASE + 32'd6));
    vecs.push_back(rd(32'd12, 32'h4444_4444));
    vecs.push_back(wr(32'd12, 4'b0101, 32'hFFFF_FFFF, 1'b1, BASE + 32'd6));
    vecs.push_back(rd(32'd12, 32'h4444_4444));
    vecs.push_back(wr(32'd15, 4'b0001, 32'h0000_0077, 1'b1, BASE + 32'd6));
    vecs.push_back(rd(32'd12, 32'h7744_4444));
    vecs.push_back(wr(32'd14, 4'b0011, 32'h0000_5566, 1'b1, BASE + 32'd6));
    vecs.push_back(rd(32'd14, 32'h0000_5566));
    vecs.push_back(rd(32'd12, 32'h5566_4444));
    vecs.push_back(wr(32'd8,  4'b1111, 32'hA5A5_A5A5, 1'b1, BASE + 32'd6));
    vecs.push_back(rd(32'd8,  32'hA5A5_A5A5));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        bus_write(BASE + vecs[i].off, vecs[i].be, vecs[i].data);
        check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
        check($sformatf("vec%0d_eaddr", i), err_addr, vecs[i].exp_eaddr);
      end else begin
        bus_read(BASE + vecs[i].off, vecs[i].exp, $sformatf("vec%0d_read", i));
      end
    end

    // Turnaround: alternate CPU-driven no-op stores (bench drives zero) with reads.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        @(negedge clk);
        dmem_addr = BASE + 32'd8;
        byte_en   = 4'b0000;
        tb_wdata  = 32'h0;
        tb_drv    = 1'b1;
        dmem_wen  = 1'b1;
        sb_q.push_back('{$sformatf("turn%0d_cpu", i), 32'h0});
        #2;
        drain_data();
      end else begin
        bus_read(BASE + 32'd8, 32'hA5A5_A5A5, $sformatf("turn%0d_read", i));
      end
    end
    idle();
    check("turn_eaddr_kept", err_addr, BASE + 32'd6);

    // Reset mid-load: pointer restarts, earlier words survive.
    do_reset("rst2");
    ld_push(32'hAAAA_0001, 1'b0, "mid0_ready");
    ld_push(32'hBBBB_0002, 1'b0, "mid1_ready");
    do_reset("rst3");
    ld_push(32'hCCCC_0003, 1'b1, "rel0_ready");
    check("rel_busy", {31'b0, busy}, 32'd0);
    bus_read(BASE + 32'd0, 32'hCCCC_0003, "rel_word0");
    bus_read(BASE + 32'd4, 32'hBBBB_0002, "rel_word1");

    // Saturating pointer: DEPTH words without ld_last end the stream.
    do_reset("rst4");
    for (int i = 0; i < DEPTH - 1; i++) begin
      ld_push(32'h100 + i, 1'b0, $sformatf("sat%0d_ready", i));
    end
    check("sat_busy_before", {31'b0, busy}, 32'd1);
    ld_push(32'h100 + DEPTH - 1, 1'b0, "sat_last_ready");
    check("sat_busy_after", {31'b0, busy}, 32'd0);
    bus_read(BASE + 4 * (DEPTH - 1), 32'h100 + DEPTH - 1, "sat_word_last");
    bus_read(BASE + 32'd0, 32'h100, "sat_word0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
